// File: rtl/emsg_pkg.sv
// Compressed check-message layout shared between the generator and the
// expander. Word layout, LSB first: min1, min2, per-edge signs, idx.
package emsg_pkg;

    // Index field is fixed-width so the word layout is independent of wc.
    localparam int IDX_W = 5;

    // Default configuration of the check-node datapath.
    localparam int DEF_W  = 6;
    localparam int DEF_WC = 18;

    function automatic int min2_lsb(input int w);
        return w - 1;
    endfunction

    function automatic int sgn_lsb(input int w);
        return 2 * (w - 1);
    endfunction

    function automatic int idx_lsb(input int w, input int wc);
        return 2 * (w - 1) + wc;
    endfunction

    function automatic int ecomp_w(input int w, input int wc);
        return idx_lsb(w, wc) + IDX_W;
    endfunction

    // Field offsets for the default configuration.
    localparam int MIN1_LSB = 0;
    localparam int MIN2_LSB = min2_lsb(DEF_W);
    localparam int SGN_LSB  = sgn_lsb(DEF_W);
    localparam int IDX_LSB  = idx_lsb(DEF_W, DEF_WC);
    localparam int ECOMP_W  = ecomp_w(DEF_W, DEF_WC);

endpackage

// File: rtl/emsg_lane.sv
// One edge of the expander: offset-corrected magnitude plus sign turned
// into a w-bit two's complement message. A zero magnitude always yields 0.
module emsg_lane #(
    parameter int w      = 6,
    parameter int OFFSET = 1
) (
    input  logic [w-2:0] mag_sel,
    input  logic         sign,
    output logic [w-1:0] msg
);

    localparam logic [w-2:0] OFS = (w-1)'(OFFSET);

    logic [w-2:0] mag_off;
    logic [w-1:0] pos;

    // Offset min-sum correction, saturating at zero.
    assign mag_off = (mag_sel > OFS) ? (mag_sel - OFS) : '0;
    assign pos     = {1'b0, mag_off};
    // Negating zero gives zero, so no negative zero can appear.
    assign msg     = sign ? -pos : pos;

endmodule

// File: rtl/emsg_expand.sv
// Check-message expander: holds one compressed word and emits its wc edge
// messages LANES at a time over a valid/ready stream. The next word is
// accepted in the same cycle the last beat is taken, so there is no bubble.
module emsg_expand
    import emsg_pkg::*;
#(
    parameter int w      = 6,
    parameter int wc     = 18,
    parameter int LANES  = 6,
    parameter int OFFSET = 1
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [2*(w-1)+wc+IDX_W-1:0]                     in_ecomp,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [LANES*w-1:0]                              out_msg,
    output logic [((wc/LANES) > 1 ? $clog2(wc/LANES) : 1)-1:0] out_beat,
    output logic                                            out_last,
    output logic                                            err_idx
);

    localparam int NBEAT  = wc / LANES;
    localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int EIW    = (wc > 1) ? $clog2(wc) : 1;
    localparam int M2L    = min2_lsb(w);
    localparam int SGL    = sgn_lsb(w);
    localparam int IXL    = idx_lsb(w, wc);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    if (wc % LANES != 0) begin : g_bad_cfg
        $error("emsg_expand: wc must be a multiple of LANES");
    end

    logic [0:0]        state_q;
    logic [BEAT_W-1:0] beat_q;
    logic [w-2:0]      min1_q;
    logic [w-2:0]      min2_q;
    logic [wc-1:0]     sgn_q;
    logic [IDX_W-1:0]  idx_q;
    logic              par_q;
    logic              err_q;

    logic [w-2:0]      in_min1;
    logic [w-2:0]      in_min2;
    logic [wc-1:0]     in_sgn;
    logic [IDX_W-1:0]  in_idx;

    logic              accept;
    logic              take;
    logic              last_beat;

    logic [LANES-1:0][w-1:0] lane_msg;

    assign in_min1 = in_ecomp[MIN1_LSB +: (w-1)];
    assign in_min2 = in_ecomp[M2L +: (w-1)];
    assign in_sgn  = in_ecomp[SGL +: wc];
    assign in_idx  = in_ecomp[IXL +: IDX_W];

    assign last_beat = (beat_q == BEAT_W'(NBEAT - 1));
    assign out_valid = (state_q == EMIT);
    assign out_last  = out_valid && last_beat;
    assign out_beat  = beat_q;
    assign take      = out_valid && out_ready;
    assign in_ready  = (state_q == IDLE) || (take && last_beat);
    assign accept    = in_valid && in_ready;
    assign err_idx   = err_q;

    // Holding register, beat counter and IDLE/EMIT state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            min1_q  <= '0;
            min2_q  <= '0;
            sgn_q   <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
        end else if (accept) begin
            state_q <= EMIT;
            beat_q  <= '0;
            min1_q  <= in_min1;
            min2_q  <= in_min2;
            sgn_q   <= in_sgn;
            idx_q   <= in_idx;
            par_q   <= ^in_sgn;
        end else if (take) begin
            if (last_beat) begin
                state_q <= IDLE;
                beat_q  <= '0;
            end else begin
                beat_q  <= beat_q + BEAT_W'(1);
            end
        end
    end

    // Sticky flag for an out-of-range min1 index; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && (32'(in_idx) >= wc)) begin
            err_q <= 1'b1;
        end
    end

    // Lane k carries edge beat*LANES+k; an out-of-range idx never matches,
    // so every edge then falls back to min1.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [EIW-1:0] edge_num;
        logic           use_min2;
        logic [w-2:0]   mag;

        assign edge_num = EIW'(32'(beat_q) * LANES + k);
        assign use_min2 = (32'(idx_q) == 32'(edge_num));
        assign mag      = use_min2 ? min2_q : min1_q;

        emsg_lane #(
            .w      (w),
            .OFFSET (OFFSET)
        ) u_lane (
            .mag_sel (mag),
            .sign    (par_q ^ sgn_q[edge_num]),
            .msg     (lane_msg[k])
        );
    end

    assign out_msg = out_valid ? lane_msg : '0;

endmodule

// File: tb/tb_emsg_expand.sv
// Directed bench for emsg_expand at w=6, wc=18, LANES=6, OFFSET=1.
module tb_emsg_expand;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] in_ecomp;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] out_msg;
    logic [1:0]  out_beat;
    logic        out_last;
    logic        err_idx;

    int npass  = 0;
    int ntotal = 0;

    emsg_expand #(
        .w      (6),
        .wc     (18),
        .LANES  (6),
        .OFFSET (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ecomp  (in_ecomp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_msg   (out_msg),
        .out_beat  (out_beat),
        .out_last  (out_last),
        .err_idx   (err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] word(input int idx, input logic [17:0] sgn,
                                         input int min2, input int min1);
        return {5'(idx), sgn, 5'(min2), 5'(min1)};
    endfunction

    // Lane a is the lowest edge of the beat.
    function automatic logic [35:0] mk(input int a, input int b, input int c,
                                       input int d, input int e, input int f);
        return {6'(f), 6'(e), 6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_ecomp  = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_msg",   64'(out_msg),   64'(0));
        chk("rst_out_beat",  64'(out_beat),  64'(0));
        chk("rst_out_last",  64'(out_last),  64'(0));
        chk("rst_err_idx",   64'(err_idx),   64'(0));

        // min1=3 min2=7 idx=4 sgn=0: edge4 +6, rest +2
        in_ecomp  = word(4, 18'h0, 7, 3);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_b0_valid", 64'(out_valid), 64'(1));
        chk("t1_b0_beat",  64'(out_beat),  64'(0));
        chk("t1_b0_msg",   64'(out_msg),   64'(mk(2, 2, 2, 2, 6, 2)));
        chk("t1_b0_last",  64'(out_last),  64'(0));
        chk("t1_b0_rdy",   64'(in_ready),  64'(0));
        step();
        chk("t1_b1_beat",  64'(out_beat),  64'(1));
        chk("t1_b1_msg",   64'(out_msg),   64'(mk(2, 2, 2, 2, 2, 2)));
        chk("t1_b1_last",  64'(out_last),  64'(0));
        step();
        chk("t1_b2_beat",  64'(out_beat),  64'(2));
        chk("t1_b2_msg",   64'(out_msg),   64'(mk(2, 2, 2, 2, 2, 2)));
        chk("t1_b2_last",  64'(out_last),  64'(1));
        step();
        chk("t1_idle_vld", 64'(out_valid), 64'(0));
        chk("t1_idle_rdy", 64'(in_ready),  64'(1));

        // sgn=1 (P=1) min1=5 min2=9 idx=0: edge0 +8, rest -4
        in_ecomp = word(0, 18'h00001, 9, 5);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t2_b0_msg", 64'(out_msg), 64'(mk(8, -4, -4, -4, -4, -4)));
        step();
        chk("t2_b1_msg", 64'(out_msg), 64'(mk(-4, -4, -4, -4, -4, -4)));
        step();
        chk("t2_b2_msg",  64'(out_msg),  64'(mk(-4, -4, -4, -4, -4, -4)));
        chk("t2_b2_last", 64'(out_last), 64'(1));
        step();

        // min1=min2=1 with mixed signs: everything saturates to 0
        in_ecomp = word(3, 18'h2AAAA, 1, 1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t3_b0_msg", 64'(out_msg), 64'(0));
        step();
        chk("t3_b1_msg", 64'(out_msg), 64'(0));
        step();
        chk("t3_b2_msg", 64'(out_msg), 64'(0));
        step();

        // Back-to-back words with out_ready 1,0,1
        in_ecomp  = word(4, 18'h0, 7, 3);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_ecomp = word(0, 18'h00001, 9, 5);
        chk("t4_a0_msg", 64'(out_msg),  64'(mk(2, 2, 2, 2, 6, 2)));
        chk("t4_a0_rdy", 64'(in_ready), 64'(0));
        step();
        chk("t4_a1_beat", 64'(out_beat), 64'(1));
        out_ready = 1'b0;
        step();
        chk("t4_stall_beat", 64'(out_beat),  64'(1));
        chk("t4_stall_vld",  64'(out_valid), 64'(1));
        chk("t4_stall_msg",  64'(out_msg),   64'(mk(2, 2, 2, 2, 2, 2)));
        chk("t4_stall_rdy",  64'(in_ready),  64'(0));
        out_ready = 1'b1;
        step();
        chk("t4_a2_beat", 64'(out_beat), 64'(2));
        chk("t4_a2_last", 64'(out_last), 64'(1));
        chk("t4_a2_rdy",  64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        chk("t4_b0_vld",  64'(out_valid), 64'(1));
        chk("t4_b0_beat", 64'(out_beat),  64'(0));
        chk("t4_b0_msg",  64'(out_msg),   64'(mk(8, -4, -4, -4, -4, -4)));
        step();
        step();
        chk("t4_b2_last", 64'(out_last), 64'(1));
        step();
        chk("t4_idle_vld", 64'(out_valid), 64'(0));
        chk("t4_err_clr",  64'(err_idx),   64'(0));

        // idx=20 out of range: all edges min1, sticky err_idx
        in_ecomp = word(20, 18'h0, 7, 3);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t5_b0_msg", 64'(out_msg), 64'(mk(2, 2, 2, 2, 2, 2)));
        chk("t5_err",    64'(err_idx), 64'(1));
        step();
        step();
        step();
        chk("t5_idle_vld", 64'(out_valid), 64'(0));
        chk("t5_err_hold", 64'(err_idx),   64'(1));

        // Reset asserted while beat 1 is on the output
        in_ecomp = word(4, 18'h0, 7, 3);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("t6_pre_beat", 64'(out_beat), 64'(1));
        rst = 1'b1;
        step();
        chk("t6_vld",  64'(out_valid), 64'(0));
        chk("t6_rdy",  64'(in_ready),  64'(1));
        chk("t6_err",  64'(err_idx),   64'(0));
        chk("t6_beat", 64'(out_beat),  64'(0));
        chk("t6_msg",  64'(out_msg),   64'(0));
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
